// File: rtl/fp_div_pkg.sv
// Shared definitions for the FP division datapath: significand widths,
// divider state encoding and the divide-by-zero quotient pattern.
package fp_div_pkg;

  localparam int MANT_W = 24;
  localparam int LZC_W  = 5;
  localparam int REM_W  = MANT_W + 1;
  localparam int CNT_W  = $clog2(MANT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic [MANT_W-1:0] QUOT_DBZ = 24'hFFFFFF;

endpackage

// File: rtl/lzc24_division.sv
// Combinational leading-zero counter for a 24-bit significand.
// Returns 0..23 for a nonzero input and 24 for an all-zero input.
module lzc24_division
  import fp_div_pkg::*;
(
  input  logic [MANT_W-1:0] data_in,
  output logic [LZC_W-1:0]  lz_count
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    lz_count = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (data_in[i]) begin
        lz_count = LZC_W'(MANT_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/mantissa_divider_seq.sv
// Iterative restoring significand divider: one quotient bit per clock,
// followed by a leading-zero count of the quotient and a sticky bit.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// DIV   | one restoring step per edge, quotient MSB first
// NORM  | latch leading-zero count and sticky from the final remainder
// DONE  | result presented with out_valid=1 until out_ready
module mantissa_divider_seq
  import fp_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] dividend,
  input  logic [MANT_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] quotient,
  output logic [LZC_W-1:0]  nshiftleft,
  output logic              sticky,
  output logic              div_by_zero
);

  div_state_t        state_q,     state_d;
  logic [REM_W-1:0]  rem_q,       rem_d;
  logic [MANT_W-1:0] div_q,       div_d;
  logic [MANT_W-1:0] quot_q,      quot_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [LZC_W-1:0]  nshift_q,    nshift_d;
  logic              sticky_q,    sticky_d;
  logic              dbz_q,       dbz_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q,  in_ready_d;

  logic              rem_ge;
  logic [REM_W-1:0]  rem_rest;
  logic [LZC_W-1:0]  quot_lz;

  lzc24_division u_lzc (
    .data_in  (quot_q),
    .lz_count (quot_lz)
  );

  // R < 2B always holds, so the restored remainder fits in MANT_W bits and
  // the left shift never drops a set bit.
  assign rem_ge   = (rem_q >= {1'b0, div_q});
  assign rem_rest = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    div_d       = div_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    nshift_d    = nshift_q;
    sticky_d    = sticky_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d      = {1'b0, dividend};
          div_d      = divisor;
          quot_d     = '0;
          cnt_d      = CNT_W'(MANT_W - 1);
          nshift_d   = '0;
          sticky_d   = 1'b0;
          in_ready_d = 1'b0;
          if (divisor == '0) begin
            quot_d      = QUOT_DBZ;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d         = rem_rest << 1;
        quot_d[cnt_q] = rem_ge;
        cnt_d         = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = NORM;
        end
      end
      NORM: begin
        nshift_d    = quot_lz;
        sticky_d    = |rem_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      div_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      nshift_q    <= '0;
      sticky_q    <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      nshift_q    <= nshift_d;
      sticky_q    <= sticky_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign nshiftleft  = nshift_q;
  assign sticky      = sticky_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mantissa_divider_seq.sv
// Directed plus light random bench for mantissa_divider_seq; expected
// results come from an arithmetic model through a scoreboard queue.
module tb_mantissa_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] dividend;
  logic [23:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] quotient;
  logic [4:0]  nshiftleft;
  logic        sticky;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] q;
    logic [4:0]  lz;
    logic        st;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mantissa_divider_seq dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .nshiftleft  (nshiftleft),
    .sticky      (sticky),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [23:0] a, input logic [23:0] b);
    exp_t        e;
    logic [46:0] num;
    logic [46:0] den;
    if (b == 24'd0) begin
      e.q   = 24'hFFFFFF;
      e.lz  = 5'd0;
      e.st  = 1'b0;
      e.dbz = 1'b1;
      e.lat = 0;
    end else begin
      num   = {a, 23'd0};
      den   = {23'd0, b};
      e.q   = 24'(num / den);
      e.st  = (num % den) != 47'd0;
      e.dbz = 1'b0;
      e.lat = 25;
      e.lz  = 5'd24;
      for (int i = 23; i >= 0; i--) begin
        if (e.q[i]) begin
          e.lz = 5'(23 - i);
          break;
        end
      end
    end
    return e;
  endfunction

  // Accept edge is the posedge between the two negedges below; latency is
  // counted in edges after it until out_valid is seen.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input int hold);
    exp_t e;
    int   lat;
    checks++;
    assert (b == 24'd0 || b[23])
    else begin
      errors++;
      $error("FAIL precondition: divisor %0h not normalised", b);
    end
    sb.push_back(model(a, b));
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 24'h5A5A5A;
    divisor  = 24'hA5A5A5;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("latency",     32'(lat),         32'(e.lat));
    chk("quotient",    32'(quotient),    32'(e.q));
    chk("nshiftleft",  32'(nshiftleft),  32'(e.lz));
    chk("sticky",      32'(sticky),      32'(e.st));
    chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
    chk("in_ready_busy", 32'(in_ready),  32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid",    32'(out_valid),  32'd1);
      chk("hold_quotient", 32'(quotient),   32'(e.q));
      chk("hold_nshift",   32'(nshiftleft), 32'(e.lz));
      chk("hold_in_ready", 32'(in_ready),   32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready",  32'(in_ready),  32'd1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 24'd0;
    divisor   = 24'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",    32'(in_ready),    32'd1);
    chk("rst_out_valid",   32'(out_valid),   32'd0);
    chk("rst_quotient",    32'(quotient),    32'd0);
    chk("rst_nshiftleft",  32'(nshiftleft),  32'd0);
    chk("rst_sticky",      32'(sticky),      32'd0);
    chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    run_op(24'h800000, 24'h800000, 0);
    run_op(24'h800000, 24'hC00000, 0);
    run_op(24'hFFFFFF, 24'h800000, 10);
    run_op(24'h000001, 24'h800000, 0);
    run_op(24'h000000, 24'h800000, 0);
    run_op(24'h123456, 24'h000000, 2);
    run_op(24'hABCDEF, 24'hFFFFFF, 0);

    // Flush in the tenth DIV cycle.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 24'h800000;
    divisor  = 24'h800000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    expect_quiet("flush_quiet", 30);

    // Reset in the fifth DIV cycle of a new operation.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 24'hC00000;
    divisor  = 24'h900000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_quotient",  32'(quotient),  32'd0);
    expect_quiet("midrst_quiet", 30);

    run_op(24'h800000, 24'h800000, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra[23:0], 24'h800000 | rb[23:0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
